// File: rtl/lsu_scheduler_if.sv
// Handshake bundle between the LSU scheduler and its dispatch, lsu and CDB neighbours.
// The scheduler uses the slave modport; the surrounding logic uses the master modport.
interface lsu_scheduler_if #(
  parameter int TAG_W = 4
);
  logic             alloc_valid;
  logic             alloc_ready;
  logic [2:0]       alloc_op;
  logic [31:0]      alloc_base;
  logic [31:0]      alloc_offset;
  logic [31:0]      alloc_sdata;
  logic [TAG_W-1:0] alloc_tag;
  logic             flush;
  logic             lsu_mem_req;
  logic [2:0]       lsu_mem_op;
  logic [31:0]      lsu_base_addr;
  logic [31:0]      lsu_offset;
  logic [31:0]      lsu_store_data;
  logic             lsu_ready;
  logic [31:0]      lsu_load_data;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             cdb_grant;
  logic             store_done;

  modport master (
    output alloc_valid, alloc_op, alloc_base, alloc_offset, alloc_sdata, alloc_tag, flush,
    output lsu_ready, lsu_load_data, cdb_grant,
    input  alloc_ready, lsu_mem_req, lsu_mem_op, lsu_base_addr, lsu_offset, lsu_store_data,
    input  cdb_valid, cdb_tag, cdb_data, store_done
  );

  modport slave (
    input  alloc_valid, alloc_op, alloc_base, alloc_offset, alloc_sdata, alloc_tag, flush,
    input  lsu_ready, lsu_load_data, cdb_grant,
    output alloc_ready, lsu_mem_req, lsu_mem_op, lsu_base_addr, lsu_offset, lsu_store_data,
    output cdb_valid, cdb_tag, cdb_data, store_done
  );
endinterface

// File: rtl/lsu_scheduler.sv
// In-order memory-op queue feeding the lsu one op at a time; load results go out on the CDB.
// Latency: enqueue->lsu_mem_req 1 cycle, load data MEM_LAT cycles after lsu acceptance, then CDB.
// Backpressure: alloc_ready drops when full; lsu_ready and cdb_grant stall the FSM. Stats: LSU_SCHED_STATS_EN.
module lsu_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  lsu_scheduler_if.slave bus
`ifdef LSU_SCHED_STATS_EN
  ,
  output logic [31:0]   stat_loads,
  output logic [31:0]   stat_stores,
  output logic [31:0]   stat_stall
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef struct packed {
    logic [2:0]       op;
    logic [31:0]      base;
    logic [31:0]      offset;
    logic [31:0]      sdata;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, CDB} state_t;

  entry_t           q_mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, empty;
  logic             enq, deq, accept;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] res_tag;
  logic [31:0]      res_data;
  logic             store_done_q;

  assign head  = q_mem[rd_ptr[IDX_W-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

  // accept is the raw lsu handshake; a flush still lets the lsu take the op, it just doesn't pop.
  assign accept = (state == REQ) && bus.lsu_ready;
  assign enq    = bus.alloc_valid && bus.alloc_ready && !bus.flush;
  assign deq    = accept && !bus.flush;

  always_ff @(posedge clk) begin
    if (enq) begin
      q_mem[wr_ptr[IDX_W-1:0]] <= '{op: bus.alloc_op, base: bus.alloc_base,
                                    offset: bus.alloc_offset, sdata: bus.alloc_sdata,
                                    tag: bus.alloc_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (!empty || enq) state_nxt = REQ;
        REQ:  if (bus.lsu_ready) state_nxt = head.op[2] ? IDLE : WAIT;
        WAIT: if (cnt == '0) state_nxt = CDB;
        CDB:  if (bus.cdb_grant) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.alloc_ready    = !full && !rst;
    bus.lsu_mem_req    = 1'b0;
    bus.lsu_mem_op     = '0;
    bus.lsu_base_addr  = '0;
    bus.lsu_offset     = '0;
    bus.lsu_store_data = '0;
    bus.cdb_valid      = 1'b0;
    bus.cdb_tag        = '0;
    bus.cdb_data       = '0;
    bus.store_done     = store_done_q;
    if (state == REQ) begin
      bus.lsu_mem_req    = 1'b1;
      bus.lsu_mem_op     = head.op;
      bus.lsu_base_addr  = head.base;
      bus.lsu_offset     = head.offset;
      bus.lsu_store_data = head.sdata;
    end
    if (state == CDB) begin
      bus.cdb_valid = 1'b1;
      bus.cdb_tag   = res_tag;
      bus.cdb_data  = res_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      res_tag      <= '0;
      res_data     <= '0;
      store_done_q <= 1'b0;
    end else begin
      store_done_q <= accept && head.op[2];
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + 1'b1;
        if (deq) rd_ptr <= rd_ptr + 1'b1;
      end
      if (accept && !head.op[2]) begin
        cnt     <= CNT_W'(MEM_LAT - 1);
        res_tag <= head.tag;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == WAIT && cnt == '0) begin
        res_data <= bus.lsu_load_data;
      end
    end
  end

`ifdef LSU_SCHED_STATS_EN
  // Counters survive flush on purpose; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_stall  <= '0;
    end else begin
      if (accept && head.op[2])  stat_stores <= stat_stores + 1'b1;
      if (accept && !head.op[2]) stat_loads  <= stat_loads + 1'b1;
      if (bus.alloc_valid && !bus.alloc_ready) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_scheduler.sv
// Directed bench for lsu_scheduler: per-cycle vector table plus fill/drain and ordering sequences.
module tb_lsu_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_scheduler_if #(.TAG_W(4)) bus ();

`ifdef LSU_SCHED_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_stall;
`endif

  lsu_scheduler #(.DEPTH(4), .TAG_W(4), .MEM_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef LSU_SCHED_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_stall  (stat_stall)
`endif
  );

  typedef struct packed {
    logic        ar;
    logic        req;
    logic [2:0]  op;
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] sd;
    logic        cv;
    logic [3:0]  ctag;
    logic [31:0] cdata;
    logic        sdone;
  } out_t;

  typedef struct {
    logic        av;
    logic [2:0]  op;
    logic [31:0] base, off, sd;
    logic [3:0]  tag;
    logic        fl, lrdy;
    logic [31:0] ld;
    logic        gnt;
    out_t        exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic out_t cur_out();
    out_t o;
    o = '{ar: bus.alloc_ready, req: bus.lsu_mem_req, op: bus.lsu_mem_op, base: bus.lsu_base_addr,
          off: bus.lsu_offset, sd: bus.lsu_store_data, cv: bus.cdb_valid, ctag: bus.cdb_tag,
          cdata: bus.cdb_data, sdone: bus.store_done};
    return o;
  endfunction

  task automatic drive(input logic av, input logic [2:0] op, input logic [31:0] base, input logic [31:0] off,
                       input logic [31:0] sd, input logic [3:0] tag, input logic fl, input logic lrdy,
                       input logic [31:0] ld, input logic gnt);
    bus.alloc_valid   = av;
    bus.alloc_op      = op;
    bus.alloc_base    = base;
    bus.alloc_offset  = off;
    bus.alloc_sdata   = sd;
    bus.alloc_tag     = tag;
    bus.flush         = fl;
    bus.lsu_ready     = lrdy;
    bus.lsu_load_data = ld;
    bus.cdb_grant     = gnt;
  endtask

  task automatic add(input logic av, input logic [2:0] op, input logic [31:0] base, input logic [31:0] off,
                     input logic [31:0] sd, input logic [3:0] tag, input logic fl, input logic lrdy,
                     input logic [31:0] ld, input logic gnt,
                     input logic e_ar, input logic e_req, input logic [2:0] e_op, input logic [31:0] e_base,
                     input logic [31:0] e_off, input logic [31:0] e_sd, input logic e_cv, input logic [3:0] e_ctag,
                     input logic [31:0] e_cdata, input logic e_sdone);
    vec_t v;
    v.av = av; v.op = op; v.base = base; v.off = off; v.sd = sd; v.tag = tag;
    v.fl = fl; v.lrdy = lrdy; v.ld = ld; v.gnt = gnt;
    v.exp = '{ar: e_ar, req: e_req, op: e_op, base: e_base, off: e_off, sd: e_sd,
              cv: e_cv, ctag: e_ctag, cdata: e_cdata, sdone: e_sdone};
    vecs.push_back(v);
  endtask

  initial begin
    int   got;
    int   n_acc;
    logic st_acc;
    logic cdb_seen;
    out_t o;

    // inputs                                               | expected outputs
    add(0,0,0,0,0,0, 0,0,0,0,                         1,0,0,0,0,0,0,0,0,0);                          // after reset
    add(1,4,32'h1000,32'h100,32'hCAFEF00D,0, 0,1,0,0, 1,0,0,0,0,0,0,0,0,0);                          // alloc store
    add(0,0,0,0,0,0, 0,1,0,0,                         1,1,4,32'h1000,32'h100,32'hCAFEF00D,0,0,0,0);  // store issued
    add(0,0,0,0,0,0, 0,1,0,0,                         1,0,0,0,0,0,0,0,0,1);                          // store_done
    add(1,2,32'h2000,32'h4,0,5, 0,1,0,0,              1,0,0,0,0,0,0,0,0,0);                          // alloc load tag 5
    add(0,0,0,0,0,0, 0,1,0,0,                         1,1,2,32'h2000,32'h4,0,0,0,0,0);
    add(0,0,0,0,0,0, 0,1,32'h11111111,0,              1,0,0,0,0,0,0,0,0,0);                          // not yet sampled
    add(0,0,0,0,0,0, 0,1,32'hDEADBEEF,0,              1,0,0,0,0,0,0,0,0,0);                          // MEM_LAT capture
    add(0,0,0,0,0,0, 0,1,0,0,                         1,0,0,0,0,0,1,5,32'hDEADBEEF,0);
    add(0,0,0,0,0,0, 0,1,0,0,                         1,0,0,0,0,0,1,5,32'hDEADBEEF,0);
    add(0,0,0,0,0,0, 0,1,0,0,                         1,0,0,0,0,0,1,5,32'hDEADBEEF,0);
    add(0,0,0,0,0,0, 0,1,0,1,                         1,0,0,0,0,0,1,5,32'hDEADBEEF,0);               // grant
    add(0,0,0,0,0,0, 0,1,0,0,                         1,0,0,0,0,0,0,0,0,0);
    add(1,2,32'h3000,0,0,7, 0,1,0,0,                  1,0,0,0,0,0,0,0,0,0);                          // flush scenario
    add(1,4,32'h4000,32'h8,32'h12345678,1, 0,1,0,0,   1,1,2,32'h3000,0,0,0,0,0,0);
    add(1,5,32'h5000,32'hC,32'h9ABCDEF0,2, 0,0,0,0,   1,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 0,0,32'hCAFEBABE,0,              1,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,                         1,0,0,0,0,0,1,7,32'hCAFEBABE,0);
    add(1,4,32'h7000,0,1,3, 1,1,0,1,                  1,0,0,0,0,0,1,7,32'hCAFEBABE,0);               // flush+alloc+grant
    add(0,0,0,0,0,0, 0,1,0,0,                         1,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 0,1,0,0,                         1,0,0,0,0,0,0,0,0,0);
    add(1,4,32'h6000,0,32'h55,0, 0,1,0,0,             1,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 1,1,0,0,                         1,1,4,32'h6000,0,32'h55,0,0,0,0);              // flush as lsu accepts
    add(0,0,0,0,0,0, 0,1,0,0,                         1,0,0,0,0,0,0,0,0,1);
    add(0,0,0,0,0,0, 0,1,0,0,                         1,0,0,0,0,0,0,0,0,0);

    drive(0,0,0,0,0,0, 0,0,0,0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].av, vecs[i].op, vecs[i].base, vecs[i].off, vecs[i].sd, vecs[i].tag,
            vecs[i].fl, vecs[i].lrdy, vecs[i].ld, vecs[i].gnt);
      #1;
      o = cur_out();
      chk($sformatf("row%0d", i), 256'(o), 256'(vecs[i].exp));
      @(negedge clk);
    end

    // Fill past DEPTH with the lsu stalled; the fifth op must be refused.
    for (int k = 0; k < 5; k++) begin
      drive(1, 3'd4, 32'hA000 + 32'(k * 16), 0, 32'(k), 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("fill_rdy%0d", k), 256'(bus.alloc_ready), 256'(k < 4));
      @(negedge clk);
    end
    drive(0,0,0,0,0,0, 0,0,0,0);
    #1;
    chk("hold_head", {bus.alloc_ready, bus.lsu_mem_req, bus.lsu_base_addr}, {1'b0, 1'b1, 32'hA000});
    @(negedge clk);

    got = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      drive(0,0,0,0,0,0, 0,1,0,0);
      #1;
      if (cyc == 0) chk("full_deq_no_rdy", 256'(bus.alloc_ready), 256'(0));
      if (cyc == 1) chk("rdy_after_deq", 256'(bus.alloc_ready), 256'(1));
      if (bus.lsu_mem_req) begin
        if (got < 4) chk($sformatf("drain_order%0d", got), 256'(bus.lsu_base_addr), 256'(32'hA000 + 32'(got * 16)));
        got++;
      end
      @(negedge clk);
    end
    chk("drain_count", 256'(got), 256'(4));

    // Store then load to the same address; the lsu stalls the store for 2 cycles.
    drive(1, 3'd4, 32'h2000, 0, 32'h77, 0, 0, 0, 0, 1);
    @(negedge clk);
    drive(1, 3'd2, 32'h2000, 0, 0, 9, 0, 0, 0, 1);
    @(negedge clk);
    n_acc = 0;
    st_acc = 1'b0;
    cdb_seen = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      drive(0,0,0,0,0,0, 0, (cyc >= 2), 32'h2000BEEF, 1);
      #1;
      if (bus.lsu_mem_req && !st_acc) chk("no_bypass", 256'(bus.lsu_mem_op[2]), 256'(1));
      if (bus.lsu_mem_req && bus.lsu_ready) begin
        chk($sformatf("issue_seq%0d", n_acc), 256'(bus.lsu_mem_op[2]), 256'(n_acc == 0));
        if (bus.lsu_mem_op[2]) st_acc = 1'b1;
        n_acc++;
      end
      if (bus.cdb_valid) begin
        chk("ld_cdb", {bus.cdb_tag, bus.cdb_data}, {4'd9, 32'h2000BEEF});
        cdb_seen = 1'b1;
      end
      @(negedge clk);
    end
    chk("order_count", 256'(n_acc), 256'(2));
    chk("ld_cdb_seen", 256'(cdb_seen), 256'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
